icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 153 +++++++++++++++
 tb/tb_icache_assoc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: 2-way set-associative instruction cache with per-set
// LRU replacement and a word-serial line fill from the memory controller.
module icache_assoc #(
   parameter int SET_BITS  = 4,
   parameter int LINE_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        IF_addr_sgn,
   input  logic [31:0] IF_addr,
   output logic        IF_val_sgn,
   output logic [31:0] IF_val,
   output logic        MC_addr_sgn,
   output logic [31:0] MC_addr,
   input  logic        MC_val_sgn,
   input  logic [31:0] MC_val
);
   localparam int SETS   = 1 << SET_BITS;
   localparam int WORDS  = 1 << LINE_BITS;
   localparam int TAG_LO = SET_BITS + LINE_BITS + 2;
   localparam int TAG_W  = 32 - TAG_LO;

   typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
   state_t state, state_nxt;

   logic [31:0]          data  [2][SETS][WORDS];
   logic [TAG_W-1:0]     tags  [2][SETS];
   logic [SETS-1:0]      valid [2];
   logic [SETS-1:0]      lru;
   logic [31:0]          req;
   logic                 victim;
   logic [LINE_BITS-1:0] cnt;
   logic                 pend;
   logic                 val_q;

   logic [LINE_BITS-1:0] in_word, rq_word;
   logic [SET_BITS-1:0]  in_set, rq_set;
   logic [TAG_W-1:0]     in_tag, rq_tag;
   logic hit0, hit1, hit, hit_way;
   logic victim_sel, lookup, fill_we, last;

   assign in_word = IF_addr[LINE_BITS+1:2];
   assign in_set  = IF_addr[LINE_BITS+2 +: SET_BITS];
   assign in_tag  = IF_addr[31:TAG_LO];
   assign rq_word = req[LINE_BITS+1:2];
   assign rq_set  = req[LINE_BITS+2 +: SET_BITS];
   assign rq_tag  = req[31:TAG_LO];

   assign hit0    = valid[0][in_set] && (tags[0][in_set] == in_tag);
   assign hit1    = valid[1][in_set] && (tags[1][in_set] == in_tag);
   // A flush in the same cycle wins over any hit.
   assign hit     = (hit0 || hit1) && !flush;
   assign hit_way = !hit0;

   assign lookup  = rdy && (state == IDLE) && IF_addr_sgn;
   assign fill_we = rdy && (state == FILL) && MC_val_sgn;
   assign last    = &cnt;

   always_comb begin
      victim_sel = lru[in_set];
      if (flush || !valid[0][in_set])
         victim_sel = 1'b0;
      else if (!valid[1][in_set])
         victim_sel = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (lookup && !hit) state_nxt = FILL;
         FILL: if (fill_we && last) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         valid[0] <= '0;
         valid[1] <= '0;
         lru      <= '0;
         cnt      <= '0;
         pend     <= 1'b0;
         val_q    <= 1'b0;
         IF_val   <= '0;
         req      <= '0;
         victim   <= 1'b0;
      end else if (!rdy) begin
         val_q <= 1'b0;
      end else begin
         state <= state_nxt;
         val_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush) begin
                  valid[0] <= '0;
                  valid[1] <= '0;
                  lru      <= '0;
               end
               if (IF_addr_sgn && hit) begin
                  val_q       <= 1'b1;
                  IF_val      <= data[hit_way][in_set][in_word];
                  lru[in_set] <= !hit_way;
               end else if (IF_addr_sgn) begin
                  req    <= IF_addr;
                  victim <= victim_sel;
                  cnt    <= '0;
               end
            end
            FILL: begin
               if (flush) pend <= 1'b1;
               if (MC_val_sgn) begin
                  cnt <= cnt + LINE_BITS'(1);
                  if (last) begin
                     valid[victim][rq_set] <= 1'b1;
                     lru[rq_set]           <= !victim;
                  end
               end
            end
            RESP: begin
               if (IF_addr_sgn && (IF_addr == req)) begin
                  val_q  <= 1'b1;
                  IF_val <= data[victim][rq_set][rq_word];
               end
               // Deferred flush also drops the line just filled.
               if (flush || pend) begin
                  valid[0] <= '0;
                  valid[1] <= '0;
                  lru      <= '0;
                  pend     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data[victim][rq_set][cnt] <= MC_val;
         if (last) tags[victim][rq_set] <= rq_tag;
      end
   end

   assign IF_val_sgn  = val_q && rdy;
   assign MC_addr_sgn = (state == FILL) && !MC_val_sgn;
   assign MC_addr     = (state == FILL) ?
                        {req[31:LINE_BITS+2], cnt, 2'b00} : '0;

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed checks of icache_assoc against a
// 2-cycle-latency memory model that logs every returned word address.
module tb_icache_assoc;
   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        if_addr_sgn;
   logic [31:0] if_addr;
   logic        if_val_sgn;
   logic [31:0] if_val;
   logic        mc_addr_sgn;
   logic [31:0] mc_addr;
   logic        mc_val_sgn;
   logic [31:0] mc_val;

   int checks = 0;
   int errors = 0;
   logic [31:0] mc_log [$];

   icache_assoc dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .IF_addr_sgn(if_addr_sgn), .IF_addr(if_addr),
      .IF_val_sgn(if_val_sgn), .IF_val(if_val),
      .MC_addr_sgn(mc_addr_sgn), .MC_addr(mc_addr),
      .MC_val_sgn(mc_val_sgn), .MC_val(mc_val)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory: answers a request on its second sampled cycle, one word per pulse.
   initial begin
      int wcnt;
      wcnt = 0;
      mc_val_sgn = 1'b0;
      mc_val = '0;
      forever begin
         @(negedge clk);
         if (mc_val_sgn) begin
            mc_val_sgn = 1'b0;
            wcnt = 0;
         end else if (mc_addr_sgn && rdy) begin
            if (wcnt == 1) begin
               mc_val_sgn = 1'b1;
               mc_val = mem_word(mc_addr);
               mc_log.push_back(mc_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else if (!mc_addr_sgn) begin
            wcnt = 0;
         end
      end
   end

   task automatic fetch(input string tag, input logic [31:0] a,
                        input bit exp_hit, input int fl_at,
                        input bit stall);
      int cyc;
      int n0;
      bit got;
      bit saw_mc;
      bit stalled;
      logic [31:0] base;
      n0 = mc_log.size();
      base = {a[31:4], 4'h0};
      cyc = 0;
      got = 1'b0;
      saw_mc = 1'b0;
      stalled = 1'b0;
      if_addr = a;
      if_addr_sgn = 1'b1;
      while (!got && cyc < 300) begin
         flush = (fl_at != 0) && (cyc == fl_at);
         @(posedge clk); #1;
         cyc++;
         saw_mc = saw_mc | mc_addr_sgn;
         if (if_val_sgn) begin
            got = 1'b1;
         end else if (stall && !stalled && (mc_log.size() - n0 == 2)) begin
            stalled = 1'b1;
            rdy = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               check({tag, "_stall_addr"}, mc_addr, base + 32'h8);
               check({tag, "_stall_ifv"}, {31'b0, if_val_sgn}, 32'h0);
            end
            rdy = 1'b1;
         end
      end
      flush = 1'b0;
      if_addr_sgn = 1'b0;
      check({tag, "_resp"}, {31'b0, got}, 32'h1);
      check({tag, "_data"}, if_val, mem_word(a));
      if (exp_hit) begin
         check({tag, "_hit_lat"}, 32'(cyc), 32'h1);
         check({tag, "_hit_nomc"}, {31'b0, saw_mc}, 32'h0);
         check({tag, "_hit_words"}, 32'(mc_log.size() - n0), 32'h0);
      end else begin
         check({tag, "_miss_words"}, 32'(mc_log.size() - n0), 32'h4);
         for (int i = 0; i < 4; i++)
            if (n0 + i < mc_log.size())
               check({tag, "_mc_addr"}, mc_log[n0+i], base + 32'(4*i));
      end
      @(posedge clk); #1;
      check({tag, "_one_pulse"}, {31'b0, if_val_sgn}, 32'h0);
      check({tag, "_val_hold"}, if_val, mem_word(a));
   endtask

   initial begin
      int cyc;
      int n0;
      rst = 1'b1;
      rdy = 1'b1;
      flush = 1'b0;
      if_addr_sgn = 1'b0;
      if_addr = '0;
      #2 rst = 1'b0;
      #2;
      check("rst_ifv_sgn", {31'b0, if_val_sgn}, 32'h0);
      check("rst_ifv", if_val, 32'h0);
      check("rst_mc_sgn", {31'b0, mc_addr_sgn}, 32'h0);
      check("rst_mc_addr", mc_addr, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // Cold miss, then hit in the same line.
      fetch("cold_1008", 32'h1008, 1'b0, 0, 1'b0);
      check("cold_a2_const", if_val, 32'h1008_EFF7);
      fetch("hit_100c", 32'h100C, 1'b1, 0, 1'b0);

      // Two ways in set 0, LRU eviction.
      fetch("fill_2000", 32'h2000, 1'b0, 0, 1'b0);
      fetch("hit_1000_a", 32'h1000, 1'b1, 0, 1'b0);
      fetch("hit_2000", 32'h2000, 1'b1, 0, 1'b0);
      fetch("touch_1000", 32'h1000, 1'b1, 0, 1'b0);
      fetch("miss_3000", 32'h3000, 1'b0, 0, 1'b0);
      fetch("hit_1000_b", 32'h1000, 1'b1, 0, 1'b0);
      fetch("evicted_2000", 32'h2000, 1'b0, 0, 1'b0);

      // Flush while idle.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      fetch("post_flush_1000", 32'h1000, 1'b0, 0, 1'b0);

      // Flush during a fill; response still delivered, line dropped.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      fetch("flush_in_fill", 32'h1000, 1'b0, 3, 1'b0);
      fetch("refill_stall", 32'h1000, 1'b0, 0, 1'b1);
      fetch("after_stall_hit", 32'h1004, 1'b1, 0, 1'b0);

      // Reset in the middle of a fill.
      n0 = mc_log.size();
      cyc = 0;
      if_addr = 32'h5000;
      if_addr_sgn = 1'b1;
      while ((mc_log.size() - n0 < 1) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rstfill_progress", 32'(mc_log.size() - n0), 32'h1);
      @(negedge clk); #1;
      check("rstfill_pre_sgn", {31'b0, mc_addr_sgn}, 32'h1);
      check("rstfill_pre_addr", mc_addr, 32'h5004);
      rst = 1'b0;
      #1;
      check("rstfill_mc_sgn", {31'b0, mc_addr_sgn}, 32'h0);
      check("rstfill_mc_addr", mc_addr, 32'h0);
      check("rstfill_ifv_sgn", {31'b0, if_val_sgn}, 32'h0);
      check("rstfill_ifv", if_val, 32'h0);
      if_addr_sgn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      fetch("after_rst_1000", 32'h1000, 1'b0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
